// File: rtl/generate_processing_element.sv
`default_nettype none
// ============================================================================
// Module   : generate_processing_element
// Brief    : Signed multiply-accumulate PE for a partial-sum chain.
//            o_psum = i_x * i_w + i_psum, delivered through D register
//            stages built with a generate loop (latency = D edges).
// Revision : 1.0 - initial release
// ============================================================================
module generate_processing_element #(
    parameter int BW1 = 16,
    parameter int BW2 = 17,
    parameter int N   = 17,
    parameter int XW  = 8,
    parameter int WW  = 8,
    parameter int D   = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic signed [XW-1:0]  i_x,
    input  logic signed [WW-1:0]  i_w,
    input  logic signed [BW1-1:0] i_psum,
    output logic signed [BW2-1:0] o_psum
);

    localparam int PW = XW + WW;

    // Full-precision product; no truncation at this step.
    logic signed [PW-1:0]  prod_w;
    // Both addends sign-extended to the accumulator width before the add.
    logic signed [N-1:0]   prod_ext_w;
    logic signed [N-1:0]   psum_ext_w;
    logic signed [N-1:0]   sum_w;
    // Sum after adaptation to the outgoing partial-sum width.
    logic signed [BW2-1:0] sum_adapt_w;

    // Pipeline: stage_d[k] is what stage_q[k] captures on the next edge.
    logic signed [BW2-1:0] stage_d [D];
    logic signed [BW2-1:0] stage_q [D];

    assign prod_w     = i_x * i_w;
    assign prod_ext_w = {{(N-PW){prod_w[PW-1]}}, prod_w};
    assign psum_ext_w = {{(N-BW1){i_psum[BW1-1]}}, i_psum};
    assign sum_w      = prod_ext_w + psum_ext_w;

    // Output-width adaptation: truncate when narrowing, sign-extend when widening.
    generate
        if (BW2 <= N) begin : g_trunc
            assign sum_adapt_w = sum_w[BW2-1:0];
        end else begin : g_sext
            assign sum_adapt_w = {{(BW2-N){sum_w[N-1]}}, sum_w};
        end
    endgenerate

    // One register per stage; stage 0 takes the fresh sum, later stages shift.
    generate
        for (genvar k = 0; k < D; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign stage_d[k] = sum_adapt_w;
            end else begin : g_tail
                assign stage_d[k] = stage_q[k-1];
            end

            // Stage register; asynchronous reset flushes in-flight results at once.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    stage_q[k] <= '0;
                end else begin
                    stage_q[k] <= stage_d[k];
                end
            end
        end
    endgenerate

    assign o_psum = stage_q[D-1];

endmodule
`default_nettype wire

// File: tb/tb_generate_processing_element.sv
`default_nettype none
// ============================================================================
// Module   : tb_generate_processing_element
// Brief    : Self-checking bench for generate_processing_element with three
//            depths (D = 1, 3, 5) sharing one stimulus stream. Expected
//            results are pushed to per-depth queues as stimulus is driven
//            and popped when the corresponding output is due.
// Revision : 1.0 - initial release
// ============================================================================
module tb_generate_processing_element;

    localparam int NI = 3;
    localparam int DEPTHS [NI] = '{1, 3, 5};

    logic               clk;
    logic               rst_n;
    logic signed [7:0]  x;
    logic signed [7:0]  w;
    logic signed [15:0] psum;
    logic signed [16:0] o_d1, o_d3, o_d5;
    logic signed [16:0] obs [NI];

    logic signed [16:0] sbq [NI][$];
    logic signed [16:0] exp_v;
    int                 checks;
    int                 errors;

    assign obs[0] = o_d1;
    assign obs[1] = o_d3;
    assign obs[2] = o_d5;

    generate_processing_element #(.BW1(16), .BW2(17), .N(17), .XW(8), .WW(8), .D(1)) u_d1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_x(x), .i_w(w), .i_psum(psum), .o_psum(o_d1));
    generate_processing_element #(.BW1(16), .BW2(17), .N(17), .XW(8), .WW(8), .D(3)) u_d3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_x(x), .i_w(w), .i_psum(psum), .o_psum(o_d3));
    generate_processing_element #(.BW1(16), .BW2(17), .N(17), .XW(8), .WW(8), .D(5)) u_d5 (
        .i_clk(clk), .i_rst_n(rst_n), .i_x(x), .i_w(w), .i_psum(psum), .o_psum(o_d5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // After reset each pipeline holds D-1 zeros ahead of the first real result.
    task automatic sb_reset();
        for (int i = 0; i < NI; i++) begin
            sbq[i].delete();
            for (int j = 0; j < DEPTHS[i] - 1; j++) sbq[i].push_back('0);
        end
    endtask

    // Drive one input set, record its expected result, then step past the edge.
    task automatic drive_edge(input int xv, input int wv, input int pv);
        int e;
        x    = xv[7:0];
        w    = wv[7:0];
        psum = pv[15:0];
        e    = xv * wv + pv;
        for (int i = 0; i < NI; i++) sbq[i].push_back(e[16:0]);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        x = 8'sd5; w = 8'sd7; psum = 16'sd3;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs[i] !== 17'sd0) begin
                errors++;
                $display("FAIL reset_hold D=%0d: got %0d expected 0", DEPTHS[i], obs[i]);
            end
        end
        // Release away from any edge: output must not move.
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs[i] !== 17'sd0) begin
                errors++;
                $display("FAIL reset_release D=%0d: got %0d expected 0", DEPTHS[i], obs[i]);
            end
        end
        sb_reset();
        @(posedge clk);
        #1;
        // The capture at this edge sampled x=5,w=7,p=3 -> 38 for D=1; others still fill.
        for (int i = 0; i < NI; i++) sbq[i].push_back(17'sd38);
        for (int i = 0; i < NI; i++) begin
            exp_v = sbq[i].pop_front();
            checks++;
            if (obs[i] !== exp_v) begin
                errors++;
                $display("FAIL reset_first_edge D=%0d: got %0d expected %0d", DEPTHS[i], obs[i], exp_v);
            end
        end
    endtask

    task automatic test_basic();
        int tx [9] = '{1, 2, 3, 3, 3, 0, 0, 0, 0};
        int tw [9] = '{5, 6, 7, 7, 7, 0, 0, 0, 0};
        int tp [9] = '{10, 5, 1, 1, 1, 0, 0, 0, 0};
        for (int n = 0; n < 9; n++) begin
            drive_edge(tx[n], tw[n], tp[n]);
            for (int i = 0; i < NI; i++) begin
                exp_v = sbq[i].pop_front();
                checks++;
                if (obs[i] !== exp_v) begin
                    errors++;
                    $display("FAIL basic[%0d] D=%0d: got %0d expected %0d", n, DEPTHS[i], obs[i], exp_v);
                end
            end
        end
    endtask

    task automatic test_signed();
        int tx [9] = '{-3, -128, 127, -128, 127, 0, 0, 0, 0};
        int tw [9] = '{4, -128, -128, 127, 127, 0, 0, 0, 0};
        int tp [9] = '{-100, 32767, -32768, -32768, 32767, 0, 0, 0, 0};
        for (int n = 0; n < 9; n++) begin
            drive_edge(tx[n], tw[n], tp[n]);
            for (int i = 0; i < NI; i++) begin
                exp_v = sbq[i].pop_front();
                checks++;
                if (obs[i] !== exp_v) begin
                    errors++;
                    $display("FAIL signed[%0d] D=%0d: got %0d expected %0d", n, DEPTHS[i], obs[i], exp_v);
                end
            end
        end
    endtask

    task automatic test_midreset();
        for (int n = 0; n < 5; n++) begin
            drive_edge(11 + n, -9, 1000 * n);
            for (int i = 0; i < NI; i++) begin
                exp_v = sbq[i].pop_front();
                checks++;
                if (obs[i] !== exp_v) begin
                    errors++;
                    $display("FAIL prefill[%0d] D=%0d: got %0d expected %0d", n, DEPTHS[i], obs[i], exp_v);
                end
            end
        end
        // Asynchronous assertion between edges clears every stage at once.
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs[i] !== 17'sd0) begin
                errors++;
                $display("FAIL midreset_clear D=%0d: got %0d expected 0", DEPTHS[i], obs[i]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb_reset();
        #1;
        for (int n = 0; n < 8; n++) begin
            if (n < 3) drive_edge(-50 + n, 3, -7);
            else       drive_edge(0, 0, 0);
            for (int i = 0; i < NI; i++) begin
                exp_v = sbq[i].pop_front();
                checks++;
                if (obs[i] !== exp_v) begin
                    errors++;
                    $display("FAIL postreset[%0d] D=%0d: got %0d expected %0d", n, DEPTHS[i], obs[i], exp_v);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int xv, wv, pv;
        for (int n = 0; n < 40; n++) begin
            xv = int'($urandom_range(255)) - 128;
            wv = int'($urandom_range(255)) - 128;
            pv = int'($urandom_range(65535)) - 32768;
            drive_edge(xv, wv, pv);
            for (int i = 0; i < NI; i++) begin
                exp_v = sbq[i].pop_front();
                checks++;
                if (obs[i] !== exp_v) begin
                    errors++;
                    $display("FAIL b2b[%0d] D=%0d: got %0d expected %0d", n, DEPTHS[i], obs[i], exp_v);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        x      = '0;
        w      = '0;
        psum   = '0;
        test_reset();
        test_basic();
        test_signed();
        test_midreset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
